ex_stage: RTL and testbench

//  Execute stage: consumes the OF/EX bundle (pc, inst, operands, immx, branchtarget, decoded flags)
//  and produces the EX/MA bundle. Evaluates ALU ops (div/mod iterative, 32 cycles) and holds the
//  E/GT compare flags. Resolves beq/bgt/b/call/ret and redirects fetch. Valid/ready both sides.

---
 rtl/ex_pkg.sv | 48 ++++
 rtl/ex_stage_seq_divider.sv | 82 ++++++++
 rtl/ex_stage.sv | 182 ++++++++++++++++++
 tb/tb_ex_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: one-hot ALU op bits, control bit positions,
// FSM states and the divide-by-zero quotient.
package ex_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  // in_alu_op one-hot bit positions
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_CMP = 2;
  localparam int ALU_MUL = 3;
  localparam int ALU_DIV = 4;
  localparam int ALU_MOD = 5;
  localparam int ALU_LSL = 6;
  localparam int ALU_LSR = 7;
  localparam int ALU_ASR = 8;
  localparam int ALU_OR  = 9;
  localparam int ALU_AND = 10;
  localparam int ALU_NOT = 11;
  localparam int ALU_MOV = 12;

  // in_ctrl bit positions
  localparam int CTRL_IMM  = 0;
  localparam int CTRL_LD   = 1;
  localparam int CTRL_ST   = 2;
  localparam int CTRL_WB   = 3;
  localparam int CTRL_BEQ  = 4;
  localparam int CTRL_BGT  = 5;
  localparam int CTRL_UBR  = 6;
  localparam int CTRL_CALL = 7;
  localparam int CTRL_RET  = 8;

  // out_ctrl bit positions
  localparam int OCTRL_LD   = 0;
  localparam int OCTRL_ST   = 1;
  localparam int OCTRL_WB   = 2;
  localparam int OCTRL_CALL = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } exState_t;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex_stage_seq_divider.sv
// Radix-2 restoring divider on magnitudes, 32 iterations after start; sign fix-up and
// divide-by-zero override are applied on the held result. Results hold until the next start.
module seq_divider
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            isSigned,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic [4:0]      cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic [XLEN-1:0] aHold;
  logic            negQ;
  logic            negR;
  logic            byZero;

  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  assign magA    = (isSigned && a[XLEN-1]) ? -a : a;
  assign magB    = (isSigned && b[XLEN-1]) ? -b : b;
  assign shifted = {acc, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      aHold  <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      byZero <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      quo    <= magA;
      dvsr   <= magB;
      aHold  <= a;
      negQ   <= isSigned && (a[XLEN-1] ^ b[XLEN-1]);
      negR   <= isSigned && a[XLEN-1];
      byZero <= (b == '0);
    end else if (busy) begin
      // Remainder never exceeds the divisor, so 32 bits of it are enough.
      if (!diff[XLEN]) begin
        acc <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        acc <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt <= cnt + 5'd1;
      if (cnt == LAST_ITER) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quot = byZero ? DIV_BY_ZERO_Q : (negQ ? -quo : quo);
  assign rem  = byZero ? aHold : (negR ? -acc : acc);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, E/GT flags, branch resolution and the EX/MA register. Latency 1,
// or 33 for div/mod; holds EX/MA and drops in_ready while MA stalls or a redirect is issued.
module ex_stage
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [XLEN-1:0] in_immx,
  input  logic [XLEN-1:0] in_branchtarget,
  input  logic [12:0]     in_alu_op,
  input  logic [8:0]      in_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_aluresult,
  output logic [XLEN-1:0] out_op2,
  output logic [3:0]      out_ctrl,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_pc,
  output logic            busy
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  exState_t        state;
  exState_t        stateNext;
  logic [4:0]      divCnt;
  logic            flagE;
  logic            flagGT;

  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [XLEN-1:0] aluRes;
  logic [3:0]      ctrlOut;
  logic            isDivMod;
  logic            takeBranch;
  logic            accept;
  logic            loadDirect;
  logic            loadDiv;

  logic [XLEN-1:0] pendPc;
  logic [XLEN-1:0] pendInst;
  logic [XLEN-1:0] pendOp2;
  logic [3:0]      pendCtrl;
  logic            pendIsMod;

  logic            divStart;
  logic            divBusy;
  logic            divDone;
  logic [XLEN-1:0] divQuot;
  logic [XLEN-1:0] divRem;

  assign opA        = in_op1;
  assign opB        = in_ctrl[CTRL_IMM] ? in_immx : in_op2;
  assign isDivMod   = in_alu_op[ALU_DIV] | in_alu_op[ALU_MOD];
  assign in_ready   = !rst && (state == IDLE) && !branch_taken && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign loadDirect = accept && !isDivMod;
  assign loadDiv    = (state == DONE) && (!out_valid || out_ready);
  assign divStart   = accept && isDivMod;
  assign busy       = (state == DIV);

  // Flags used here are the ones held before this edge, so a cmp just ahead is visible.
  assign takeBranch = in_ctrl[CTRL_UBR] | in_ctrl[CTRL_CALL] | in_ctrl[CTRL_RET]
                    | (in_ctrl[CTRL_BEQ] & flagE) | (in_ctrl[CTRL_BGT] & flagGT);

  assign ctrlOut = {in_ctrl[CTRL_CALL], in_ctrl[CTRL_WB] & ~in_alu_op[ALU_CMP],
                    in_ctrl[CTRL_ST], in_ctrl[CTRL_LD]};

  always_comb begin
    aluRes = opA + opB;
    if (in_alu_op[ALU_SUB] || in_alu_op[ALU_CMP]) aluRes = opA - opB;
    else if (in_alu_op[ALU_MUL])                  aluRes = opA * opB;
    else if (in_alu_op[ALU_LSL])                  aluRes = opA << opB[4:0];
    else if (in_alu_op[ALU_LSR])                  aluRes = opA >> opB[4:0];
    else if (in_alu_op[ALU_ASR])                  aluRes = $signed(opA) >>> opB[4:0];
    else if (in_alu_op[ALU_OR])                   aluRes = opA | opB;
    else if (in_alu_op[ALU_AND])                  aluRes = opA & opB;
    else if (in_alu_op[ALU_NOT])                  aluRes = ~opB;
    else if (in_alu_op[ALU_MOV])                  aluRes = opB;
    if (in_ctrl[CTRL_CALL])                       aluRes = in_pc + 32'd4;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (divStart) stateNext = DIV;
      DIV:     if (divCnt == LAST_ITER) stateNext = DONE;
      DONE:    if (!out_valid || out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt        <= '0;
      flagE         <= 1'b0;
      flagGT        <= 1'b0;
      branch_taken  <= 1'b0;
      branch_pc     <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_inst      <= '0;
      out_aluresult <= '0;
      out_op2       <= '0;
      out_ctrl      <= '0;
      pendPc        <= '0;
      pendInst      <= '0;
      pendOp2       <= '0;
      pendCtrl      <= '0;
      pendIsMod     <= 1'b0;
    end else begin
      branch_taken <= 1'b0;
      divCnt       <= (state == DIV) ? divCnt + 5'd1 : 5'd0;

      if (accept && in_alu_op[ALU_CMP]) begin
        flagE  <= (opA == opB);
        flagGT <= ($signed(opA) > $signed(opB));
      end
      if (accept && takeBranch) begin
        branch_taken <= 1'b1;
        branch_pc    <= in_ctrl[CTRL_RET] ? opA : in_branchtarget;
      end

      if (divStart) begin
        pendPc    <= in_pc;
        pendInst  <= in_inst;
        pendOp2   <= in_op2;
        pendCtrl  <= ctrlOut;
        pendIsMod <= in_alu_op[ALU_MOD];
      end

      if (loadDirect) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_inst      <= in_inst;
        out_aluresult <= aluRes;
        out_op2       <= in_op2;
        out_ctrl      <= ctrlOut;
      end else if (loadDiv) begin
        out_valid     <= 1'b1;
        out_pc        <= pendPc;
        out_inst      <= pendInst;
        out_aluresult <= pendIsMod ? divRem : divQuot;
        out_op2       <= pendOp2;
        out_ctrl      <= pendCtrl;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  seq_divider uDiv (
    .clk      (clk),
    .rst      (rst),
    .start    (divStart),
    .a        (opA),
    .b        (opB),
    .isSigned (1'b1),
    .busy     (divBusy),
    .done     (divDone),
    .quot     (divQuot),
    .rem      (divRem)
  );

  // The stage FSM sequences the divide itself; the divider's status is only informational.
  logic unusedDivStatus;
  assign unusedDivStatus = divBusy ^ divDone;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, flags/branches, divider timing, backpressure, reset abort.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_inst, in_op1, in_op2, in_immx, in_branchtarget;
  logic [12:0] in_alu_op;
  logic [8:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_inst, out_aluresult, out_op2;
  logic [3:0]  out_ctrl;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [12:0] OP_NONE = 13'd0;
  localparam logic [12:0] OP_ADD  = 13'd1 << ALU_ADD;
  localparam logic [12:0] OP_SUB  = 13'd1 << ALU_SUB;
  localparam logic [12:0] OP_CMP  = 13'd1 << ALU_CMP;
  localparam logic [12:0] OP_DIV  = 13'd1 << ALU_DIV;
  localparam logic [12:0] OP_MOD  = 13'd1 << ALU_MOD;
  localparam logic [8:0]  C_IMM   = 9'd1 << CTRL_IMM;
  localparam logic [8:0]  C_WB    = 9'd1 << CTRL_WB;
  localparam logic [8:0]  C_BEQ   = 9'd1 << CTRL_BEQ;
  localparam logic [8:0]  C_BGT   = 9'd1 << CTRL_BGT;
  localparam logic [8:0]  C_CALL  = 9'd1 << CTRL_CALL;
  localparam logic [8:0]  C_RET   = 9'd1 << CTRL_RET;

  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_op1(in_op1), .in_op2(in_op2),
    .in_immx(in_immx), .in_branchtarget(in_branchtarget), .in_alu_op(in_alu_op),
    .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_aluresult(out_aluresult), .out_op2(out_op2),
    .out_ctrl(out_ctrl), .branch_taken(branch_taken), .branch_pc(branch_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleIn();
    in_valid = 1'b0; in_pc = '0; in_inst = '0; in_op1 = '0; in_op2 = '0;
    in_immx = '0; in_branchtarget = '0; in_alu_op = '0; in_ctrl = '0;
  endtask

  task automatic issue(input logic [12:0] op, input logic [8:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] bt);
    in_valid = 1'b1; in_alu_op = op; in_ctrl = ctrl; in_op1 = a; in_op2 = b;
    in_immx = imm; in_pc = pc; in_inst = pc ^ 32'hA5A5_0000; in_branchtarget = bt;
  endtask

  task automatic doDiv(input string tag, input logic [12:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int n;
    issue(op, C_WB, a, b, 32'd0, 32'h300, 32'd0);
    step();
    idleIn();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    check({tag, "_busycycles"}, 32'(n), 32'd32);
    check({tag, "_notyet"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, out_aluresult, exp);
    step();
  endtask

  initial begin
    int sawValid;
    idleIn();
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_branch", 32'(branch_taken), 32'd0);
    check("rst_alu", out_aluresult, 32'd0);
    check("rst_flagE", 32'(dut.flagE), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // add immediate
    issue(OP_ADD, C_IMM | C_WB, 32'd5, 32'd99, 32'd3, 32'h10, 32'd0);
    step();
    idleIn();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", out_aluresult, 32'd8);
    check("add_ctrl", 32'(out_ctrl), 32'h4);
    check("add_pc", out_pc, 32'h10);
    step();
    check("add_drained", 32'(out_valid), 32'd0);

    // cmp 7,7 then beq; a wrong-path bundle is offered during the redirect cycle
    issue(OP_CMP, C_WB, 32'd7, 32'd7, 32'd0, 32'h20, 32'd0);
    step();
    check("cmp_result", out_aluresult, 32'd0);
    check("cmp_nowb", 32'(out_ctrl), 32'h0);
    issue(OP_NONE, C_BEQ, 32'h10, 32'h4, 32'd0, 32'h24, 32'h40);
    step();
    issue(OP_ADD, C_IMM | C_WB, 32'd1, 32'd0, 32'd1, 32'h28, 32'd0);
    check("beq_taken", 32'(branch_taken), 32'd1);
    check("beq_pc", branch_pc, 32'h40);
    check("beq_in_ready", 32'(in_ready), 32'd0);
    check("beq_addr", out_aluresult, 32'h14);
    step();
    idleIn();
    check("beq_pulse_end", 32'(branch_taken), 32'd0);
    check("wrongpath_ignored", 32'(out_valid), 32'd0);

    // bgt with GT=0 not taken, then cmp 9>3 makes it taken
    issue(OP_NONE, C_BGT, 32'd0, 32'd0, 32'd0, 32'h30, 32'h80);
    step();
    idleIn();
    check("bgt_not_taken", 32'(branch_taken), 32'd0);
    check("bgt_nt_valid", 32'(out_valid), 32'd1);
    issue(OP_CMP, 9'd0, 32'd9, 32'd3, 32'd0, 32'h34, 32'd0);
    step();
    issue(OP_NONE, C_BGT, 32'd0, 32'd0, 32'd0, 32'h38, 32'h88);
    step();
    idleIn();
    check("bgt_taken", 32'(branch_taken), 32'd1);
    check("bgt_pc", branch_pc, 32'h88);
    step();

    // divider
    doDiv("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    doDiv("mod_m7_2", OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    doDiv("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    doDiv("div_by0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    doDiv("mod_by0", OP_MOD, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7);

    // backpressure: sub held for four cycles
    out_ready = 1'b0;
    issue(OP_SUB, C_WB, 32'd10, 32'd3, 32'd0, 32'h40, 32'd0);
    step();
    issue(OP_ADD, C_IMM | C_WB, 32'd1, 32'd0, 32'd1, 32'h44, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_result", i), out_aluresult, 32'd7);
      check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", 32'(in_ready), 32'd1);
    step();
    idleIn();
    check("resume_result", out_aluresult, 32'd2);
    check("resume_pc", out_pc, 32'h44);
    step();

    // call and ret
    issue(OP_NONE, C_CALL | C_WB, 32'd0, 32'd0, 32'd0, 32'h100, 32'h200);
    step();
    idleIn();
    check("call_link", out_aluresult, 32'h104);
    check("call_ctrl", 32'(out_ctrl), 32'hC);
    check("call_taken", 32'(branch_taken), 32'd1);
    check("call_target", branch_pc, 32'h200);
    step();
    issue(OP_NONE, C_RET, 32'h104, 32'd0, 32'd0, 32'h200, 32'h999);
    step();
    idleIn();
    check("ret_taken", 32'(branch_taken), 32'd1);
    check("ret_target", branch_pc, 32'h104);
    step();

    // reset in the middle of a divide (GT is 1 from the earlier cmp)
    check("pre_rst_flagGT", 32'(dut.flagGT), 32'd1);
    issue(OP_DIV, C_WB, 32'd50, 32'd5, 32'd0, 32'h500, 32'd0);
    step();
    idleIn();
    repeat (10) step();
    check("mid_div_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_flagE", 32'(dut.flagE), 32'd0);
    check("abort_flagGT", 32'(dut.flagGT), 32'd0);
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) sawValid = 1;
    end
    check("abort_no_result", 32'(sawValid), 32'd0);
    issue(OP_NONE, C_BGT, 32'd0, 32'd0, 32'd0, 32'h600, 32'h700);
    step();
    idleIn();
    check("abort_bgt_not_taken", 32'(branch_taken), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
